// File: rtl/pio_irq_service_master_if.sv
// Avalon-MM bus bundle between the interrupt service initiator and the
// edge-capture PIO slave.
interface pio_irq_service_master_if;
  logic [1:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;

  modport master (
    output av_address,
    output av_chipselect,
    output av_write_n,
    output av_writedata,
    input  av_readdata
  );

  modport slave (
    input  av_address,
    input  av_chipselect,
    input  av_write_n,
    input  av_writedata,
    output av_readdata
  );
endinterface

// File: rtl/pio_irq_service_master.sv
// Hardware interrupt service for a push-button edge-capture PIO: programs the
// mask, then on each irq reads/clears edge_capture, reads the level, emits an event.
module pio_irq_service_master #(
  parameter int             W            = 2,
  parameter logic [W-1:0]   IRQ_MASK     = 2'b11,
  parameter int             READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      irq,
  input  logic                      enable,
  pio_irq_service_master_if.master  av,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [W-1:0]              ev_edges,
  output logic [W-1:0]              ev_level,
  output logic [15:0]               ev_count,
  output logic [7:0]                spurious_count
);

  localparam logic [2:0] INIT     = 3'd0;
  localparam logic [2:0] IDLE     = 3'd1;
  localparam logic [2:0] RD_CAP   = 3'd2;
  localparam logic [2:0] WAIT_CAP = 3'd3;
  localparam logic [2:0] CLR      = 3'd4;
  localparam logic [2:0] RD_LVL   = 3'd5;
  localparam logic [2:0] WAIT_LVL = 3'd6;
  localparam logic [2:0] PUSH     = 3'd7;

  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [2:0]   state_reg;
  logic [1:0]   cnt_reg;
  logic         cs_reg;
  logic         write_n_reg;
  logic [1:0]   addr_reg;
  logic [31:0]  wdata_reg;
  logic         valid_reg;
  logic [W-1:0] edges_reg;
  logic [W-1:0] level_reg;
  logic [15:0]  ev_count_reg;
  logic [7:0]   spur_reg;

  logic [W-1:0] rd_low;
  logic         unused_rd_high;

  assign rd_low         = av.av_readdata[W-1:0];
  assign unused_rd_high = &{1'b0, av.av_readdata[31:W]};

  // Bus strobes are registered: a state sets them for the following cycle,
  // which is when the access is actually presented to the slave.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= INIT;
      cnt_reg      <= 2'd0;
      cs_reg       <= 1'b0;
      write_n_reg  <= 1'b1;
      addr_reg     <= 2'd0;
      wdata_reg    <= 32'd0;
      valid_reg    <= 1'b0;
      edges_reg    <= '0;
      level_reg    <= '0;
      ev_count_reg <= 16'd0;
      spur_reg     <= 8'd0;
    end else begin
      cs_reg      <= 1'b0;
      write_n_reg <= 1'b1;
      case (state_reg)
        INIT: begin
          cs_reg      <= 1'b1;
          write_n_reg <= 1'b0;
          addr_reg    <= ADDR_MASK;
          wdata_reg   <= 32'(IRQ_MASK);
          state_reg   <= IDLE;
        end
        IDLE: begin
          if (irq && enable) state_reg <= RD_CAP;
        end
        RD_CAP: begin
          cs_reg    <= 1'b1;
          addr_reg  <= ADDR_EDGE;
          cnt_reg   <= 2'd0;
          state_reg <= WAIT_CAP;
        end
        WAIT_CAP: begin
          if (cnt_reg == LAT) begin
            edges_reg <= rd_low;
            if (rd_low == '0) begin
              if (spur_reg != 8'hFF) spur_reg <= spur_reg + 8'd1;
              state_reg <= IDLE;
            end else begin
              cs_reg      <= 1'b1;
              write_n_reg <= 1'b0;
              addr_reg    <= ADDR_EDGE;
              wdata_reg   <= 32'hFFFF_FFFF;
              state_reg   <= CLR;
            end
          end else begin
            cnt_reg <= cnt_reg + 2'd1;
          end
        end
        CLR: begin
          cs_reg    <= 1'b1;
          addr_reg  <= ADDR_DATA;
          state_reg <= RD_LVL;
        end
        RD_LVL: begin
          // The level read is on the bus during RD_LVL itself, so one cycle
          // of latency has already elapsed on entry to WAIT_LVL.
          cnt_reg   <= 2'd1;
          state_reg <= WAIT_LVL;
        end
        WAIT_LVL: begin
          if (cnt_reg == LAT) begin
            level_reg <= rd_low;
            valid_reg <= 1'b1;
            state_reg <= PUSH;
          end else begin
            cnt_reg <= cnt_reg + 2'd1;
          end
        end
        PUSH: begin
          if (ev_ready) begin
            valid_reg <= 1'b0;
            if (ev_count_reg != 16'hFFFF) ev_count_reg <= ev_count_reg + 16'd1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= INIT;
      endcase
    end
  end

  assign av.av_chipselect = cs_reg;
  assign av.av_write_n    = write_n_reg;
  assign av.av_address    = addr_reg;
  assign av.av_writedata  = wdata_reg;

  assign ev_valid       = valid_reg;
  assign ev_edges       = edges_reg;
  assign ev_level       = level_reg;
  assign ev_count       = ev_count_reg;
  assign spurious_count = spur_reg;

endmodule

// File: tb/tb_pio_irq_service_master.sv
// Bench for pio_irq_service_master: behavioural edge-capture PIO slave, a
// transaction-level access/event scoreboard, directed steps plus random buttons.
module tb_pio_irq_service_master;
  localparam int W  = 2;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic ev_ready = 1'b0;
  logic force_irq = 1'b0;
  logic irq;
  logic ev_valid;
  logic [W-1:0] ev_edges;
  logic [W-1:0] ev_level;
  logic [15:0] ev_count;
  logic [7:0] spurious_count;

  int vectors = 0;
  int miscompares = 0;

  pio_irq_service_master_if bus ();

  pio_irq_service_master #(
    .W(W),
    .IRQ_MASK(2'b11),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .irq(irq),
    .enable(enable),
    .av(bus),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_edges(ev_edges),
    .ev_level(ev_level),
    .ev_count(ev_count),
    .spurious_count(spurious_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural PIO: falling edges set capture bits, writing 1s to address 3 clears them.
  logic [1:0]  in_port = 2'b01;
  logic [1:0]  in_prev;
  logic [1:0]  cap;
  logic [1:0]  mask;
  logic [1:0]  rd_val;
  logic [31:0] rd_data [RL];
  logic        rd_v [RL];

  always_comb begin
    rd_val = 2'b00;
    case (bus.av_address)
      2'd0:    rd_val = in_port;
      2'd2:    rd_val = mask;
      2'd3:    rd_val = cap;
      default: rd_val = 2'b00;
    endcase
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      cap     <= 2'b00;
      mask    <= 2'b00;
      in_prev <= in_port;
      for (int i = 0; i < RL; i++) rd_v[i] <= 1'b0;
    end else begin
      in_prev <= in_port;
      cap <= ((bus.av_chipselect && !bus.av_write_n && bus.av_address == 2'd3)
              ? (cap & ~bus.av_writedata[1:0]) : cap) | (in_prev & ~in_port);
      if (bus.av_chipselect && !bus.av_write_n && bus.av_address == 2'd2)
        mask <= bus.av_writedata[1:0];
      rd_v[0]    <= bus.av_chipselect && bus.av_write_n;
      rd_data[0] <= {30'h2AAA_AAAA, rd_val};
      for (int i = 1; i < RL; i++) begin
        rd_v[i]    <= rd_v[i-1];
        rd_data[i] <= rd_data[i-1];
      end
    end
  end

  assign bus.av_readdata = rd_v[RL-1] ? rd_data[RL-1] : 32'h5A5A_5A5A;
  assign irq = force_irq | (|(cap & mask));

  // Scoreboard: a service is R3, then W3 FFFF_FFFF and R0 only if the capture was nonzero.
  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
  } acc_t;

  acc_t acc_q [$];
  logic [3:0] ev_q [$];
  acc_t e_acc;
  acc_t o_acc;
  logic [3:0] e_ev;
  int acc_total = 0;
  int mask_writes = 0;
  int ev_cnt_exp = 0;
  int spur_exp = 0;
  logic expect_init = 1'b1;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [1:0] pend_edges = 2'b00;
  logic [1:0] prev_edges = 2'b00;
  logic [1:0] prev_level = 2'b00;

  always @(negedge clk) begin
    if (!reset_n) begin
      acc_q.delete();
      ev_q.delete();
      ev_cnt_exp  = 0;
      spur_exp    = 0;
      expect_init = 1'b1;
      prev_valid  = 1'b0;
      prev_ready  = 1'b0;
    end else begin
      if (bus.av_chipselect) begin
        acc_total++;
        o_acc.wr   = ~bus.av_write_n;
        o_acc.addr = bus.av_address;
        o_acc.data = bus.av_writedata;
        if (expect_init) begin
          e_acc = '{wr: 1'b1, addr: 2'd2, data: 32'h3};
          expect_init = 1'b0;
        end else if (acc_q.size() > 0) begin
          e_acc = acc_q.pop_front();
        end else begin
          e_acc = '{wr: 1'b0, addr: 2'd3, data: 32'h0};
        end
        check("access_kind", 32'({o_acc.wr, o_acc.addr}), 32'({e_acc.wr, e_acc.addr}));
        if (o_acc.wr) check("access_wdata", o_acc.data, e_acc.data);
        if ({o_acc.wr, o_acc.addr} == {e_acc.wr, e_acc.addr}) begin
          if (o_acc.wr && o_acc.addr == 2'd2) mask_writes++;
          if (!o_acc.wr && o_acc.addr == 2'd3) begin
            if (cap != 2'b00) begin
              pend_edges = cap;
              acc_q.push_back('{wr: 1'b1, addr: 2'd3, data: 32'hFFFF_FFFF});
              acc_q.push_back('{wr: 1'b0, addr: 2'd0, data: 32'h0});
            end else if (spur_exp < 255) begin
              spur_exp++;
            end
          end
          if (!o_acc.wr && o_acc.addr == 2'd0) ev_q.push_back({pend_edges, in_port});
        end
      end else begin
        check("idle_write_n", 32'(bus.av_write_n), 32'd1);
      end

      if (prev_valid && !prev_ready) begin
        check("valid_held", 32'(ev_valid), 32'd1);
        check("edges_held", 32'(ev_edges), 32'(prev_edges));
        check("level_held", 32'(ev_level), 32'(prev_level));
      end
      if (ev_valid && ev_ready) begin
        check("event_expected", 32'(ev_q.size() > 0), 32'd1);
        if (ev_q.size() > 0) begin
          e_ev = ev_q.pop_front();
          check("event_edges", 32'(ev_edges), 32'(e_ev[3:2]));
          check("event_level", 32'(ev_level), 32'(e_ev[1:0]));
        end
        check("ev_count_at_handshake", 32'(ev_count), 32'(ev_cnt_exp));
        if (ev_cnt_exp < 65535) ev_cnt_exp++;
      end
      prev_valid = ev_valid;
      prev_ready = ev_ready;
      prev_edges = ev_edges;
      prev_level = ev_level;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"}, 32'(bus.av_chipselect), 32'd0);
    check({tag, "_write_n"}, 32'(bus.av_write_n), 32'd1);
    check({tag, "_addr"}, 32'(bus.av_address), 32'd0);
    check({tag, "_wdata"}, bus.av_writedata, 32'd0);
    check({tag, "_valid"}, 32'(ev_valid), 32'd0);
    check({tag, "_edges"}, 32'(ev_edges), 32'd0);
    check({tag, "_level"}, 32'(ev_level), 32'd0);
    check({tag, "_ev_count"}, 32'(ev_count), 32'd0);
    check({tag, "_spurious"}, 32'(spurious_count), 32'd0);
  endtask

  initial begin
    int n;
    int base_acc;
    int base_mw;
    logic seen;
    logic idx;

    // Reset and mask programming
    in_port = 2'b01;
    reset_n = 1'b0;
    enable = 1'b1;
    ev_ready = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick(4);
    check("init_mask_writes", 32'(mask_writes), 32'd1);
    check("init_access_total", 32'(acc_total), 32'd1);
    check("init_mask_reg", 32'(mask), 32'h3);
    check("init_idle_cs", 32'(bus.av_chipselect), 32'd0);

    // Button0 press, consumer ready
    ev_ready = 1'b1;
    base_acc = acc_total;
    in_port = 2'b00;
    n = 0;
    while (!irq && n < 10) begin tick(); n++; end
    check("irq_rise", 32'(irq), 32'd1);
    n = 0;
    while (!ev_valid && n < 30) begin tick(); n++; end
    check("irq_to_valid_cycles", 32'(n), 32'(5 + 2 * RL));
    check("b0_edges", 32'(ev_edges), 32'h1);
    check("b0_level", 32'(ev_level), 32'h0);
    tick();
    check("b0_ev_count", 32'(ev_count), 32'd1);
    check("b0_valid_drop", 32'(ev_valid), 32'd0);
    check("b0_accesses", 32'(acc_total - base_acc), 32'd3);

    // Back-pressure: two presses of both buttons while not ready
    ev_ready = 1'b0;
    base_acc = acc_total;
    in_port = 2'b11;
    tick(2);
    in_port = 2'b00;
    tick(10);
    in_port = 2'b11;
    tick(4);
    in_port = 2'b00;
    tick(6);
    check("bp_valid", 32'(ev_valid), 32'd1);
    check("bp_edges", 32'(ev_edges), 32'h3);
    check("bp_irq_pending", 32'(irq), 32'd1);
    check("bp_accesses", 32'(acc_total - base_acc), 32'd3);
    ev_ready = 1'b1;
    tick(30);
    check("bp_ev_count", 32'(ev_count), 32'd3);
    check("bp_irq_cleared", 32'(irq), 32'd0);
    check("bp_valid_low", 32'(ev_valid), 32'd0);

    // Spurious interrupt: irq with an empty capture register
    base_acc = acc_total;
    force_irq = 1'b1;
    tick();
    force_irq = 1'b0;
    tick(10);
    check("spur_count", 32'(spurious_count), 32'd1);
    check("spur_accesses", 32'(acc_total - base_acc), 32'd1);
    check("spur_no_event", 32'(ev_valid), 32'd0);
    check("spur_ev_count", 32'(ev_count), 32'd3);

    // enable=0 holds off service; raising it starts one
    enable = 1'b0;
    force_irq = 1'b1;
    base_acc = acc_total;
    tick(50);
    check("disabled_no_bus", 32'(acc_total - base_acc), 32'd0);
    enable = 1'b1;
    n = 0;
    while (!bus.av_chipselect && n < 5) begin tick(); n++; end
    check("enable_to_read_access", 32'(n), 32'd2);
    check("enable_read_addr", 32'({bus.av_write_n, bus.av_address}), 32'h7);
    force_irq = 1'b0;
    tick(10);
    check("enable_spur_count", 32'(spurious_count), 32'd2);

    // Random button activity with random back-pressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idx = 1'($urandom_range(0, 1));
        in_port[idx] = ~in_port[idx];
      end
      ev_ready = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 15) != 0);
      tick();
    end
    ev_ready = 1'b1;
    enable = 1'b1;
    tick(60);
    check("rand_ev_count", 32'(ev_count), 32'(ev_cnt_exp));
    check("rand_spurious", 32'(spurious_count), 32'(spur_exp));
    check("rand_queue_drained", 32'(ev_q.size()), 32'd0);
    check("rand_valid_low", 32'(ev_valid), 32'd0);

    // Reset while waiting for the level read
    in_port = 2'b11;
    tick(3);
    in_port = 2'b10;
    n = 0;
    while (!(bus.av_chipselect && bus.av_write_n && bus.av_address == 2'd0) && n < 30) begin
      tick();
      n++;
    end
    check("found_level_read", 32'(n < 30), 32'd1);
    tick();
    base_mw = mask_writes;
    reset_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ev_valid) seen = 1'b1;
    end
    check("midreset_no_valid", 32'(seen), 32'd0);
    check("midreset_mask_rewrite", 32'(mask_writes - base_mw), 32'd1);
    check("midreset_mask_reg", 32'(mask), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
